// File: rtl/chu_i2c_tgt_pkg.sv
// Shared types and register map for the I2C target slot core.
// Holds the FSM state encoding, slot addresses and STATUS bit positions.
package chu_i2c_tgt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        PTR,
        ACK_P,
        WDATA,
        ACK_W,
        RDATA,
        RACK
    } state_t;

    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] BANK_BASE  = 5'd16;

    localparam int ST_BUSY    = 0;
    localparam int ST_WR_DONE = 1;
    localparam int ST_RD_DONE = 2;
    localparam int ST_PTR_LSB = 8;

endpackage

// File: rtl/chu_i2c_tgt_filter.sv
// Purpose: synchronize one I2C line, reject pulses shorter than FILT cycles, flag edges.
// Latency: filtered level and rise/fall pulses follow the pin by 2+FILT clk cycles.
// Backpressure: none; free-running conditioning path.
module chu_i2c_tgt_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILT + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle bus level is high, so resetting to 1 avoids a spurious edge at release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            lvl  <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT - 1)) begin
                lvl  <= sync[1];
                rise <= sync[1];
                fall <= ~sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chu_i2c_target_core.sv
// Purpose: I2C target exposing a 16-byte EEPROM-style bank, shared with the slot bus.
// Latency: sda drive reacts 2+FILT+1 clk cycles after a pin edge; slot reads are combinational.
// Backpressure: none; no clock stretching, slot accesses always complete in one cycle.
module chu_i2c_target_core
    import chu_i2c_tgt_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    output logic [31:0] rd_data,
    input  logic [31:0] wr_data,
    input  logic        scl,
    inout  wire         sda
);
    state_t      state, state_nxt;
    logic [7:0]  ctrl;
    logic [7:0]  bank [16];
    logic [7:0]  shreg;
    logic [7:0]  tx;
    logic [3:0]  bit_cnt;
    logic [3:0]  ptr;
    logic        wr_done, rd_done;
    logic        scl_lvl, scl_rise, scl_fall;
    logic        sda_lvl, sda_rise, sda_fall;
    logic        start, stop, byte_done, addr_match, slot_wr, busy, sda_low;
    logic        unused_bits;

    assign unused_bits = ^{read, wr_data[31:8]};

    chu_i2c_tgt_filter #(.FILT(FILT)) u_scl_filt (
        .clk(clk), .reset(reset), .pin(scl), .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    chu_i2c_tgt_filter #(.FILT(FILT)) u_sda_filt (
        .clk(clk), .reset(reset), .pin(sda), .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start      = sda_fall & scl_lvl;
    assign stop       = sda_rise & scl_lvl;
    assign byte_done  = scl_fall && (bit_cnt == 4'd8);
    assign addr_match = (shreg[7:1] == ctrl[6:0]);
    assign slot_wr    = cs && write;
    assign busy       = (state != IDLE) && (state != ADDR);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ctrl[7])   state_nxt = IDLE;
        else if (start) state_nxt = ADDR;
        else if (stop)  state_nxt = IDLE;
        else begin
            case (state)
                ADDR:         if (byte_done) state_nxt = addr_match ? ACK_A : IDLE;
                ACK_A:        if (scl_fall)  state_nxt = shreg[0] ? RDATA : PTR;
                PTR:          if (byte_done) state_nxt = ACK_P;
                ACK_P, ACK_W: if (scl_fall)  state_nxt = WDATA;
                WDATA:        if (byte_done) state_nxt = ACK_W;
                RDATA:        if (scl_fall && bit_cnt == 4'd7) state_nxt = RACK;
                RACK: begin
                    if (scl_rise && sda_lvl) state_nxt = IDLE;
                    else if (byte_done)      state_nxt = RDATA;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        case (state)
            ACK_A, ACK_P, ACK_W: sda_low = 1'b1;
            RDATA:               sda_low = ~tx[7];
            default:             sda_low = 1'b0;
        endcase
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

    // I2C updates come after slot updates so the I2C side wins a same-cycle bank collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl    <= '0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            ptr     <= '0;
            shreg   <= '0;
            tx      <= '0;
            bit_cnt <= '0;
            for (int i = 0; i < 16; i++) bank[i] <= '0;
        end else begin
            if (slot_wr && addr == REG_CTRL) ctrl <= wr_data[7:0];
            if (slot_wr && addr == REG_STATUS) begin
                wr_done <= wr_done & ~wr_data[ST_WR_DONE];
                rd_done <= rd_done & ~wr_data[ST_RD_DONE];
            end
            if (slot_wr && addr >= BANK_BASE) bank[addr[3:0]] <= wr_data[7:0];

            if (ctrl[7] && start) begin
                bit_cnt <= '0;
            end else if (ctrl[7] && !stop) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt <= '0;
                            if (state == PTR) ptr <= shreg[3:0];
                            if (state == WDATA) begin
                                bank[ptr] <= shreg;
                                ptr       <= ptr + 4'd1;
                                wr_done   <= 1'b1;
                            end
                        end
                    end
                    ACK_A: if (scl_fall && shreg[0]) tx <= bank[ptr];
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                ptr     <= ptr + 4'd1;
                                bit_cnt <= '0;
                            end else begin
                                tx      <= {tx[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // bit_cnt==8 marks an ACK seen on the 9th clock; the next byte loads on its fall.
                    RACK: begin
                        if (scl_rise) begin
                            if (sda_lvl) rd_done <= 1'b1;
                            else         bit_cnt <= 4'd8;
                        end else if (byte_done) begin
                            tx      <= bank[ptr];
                            bit_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr == REG_CTRL) begin
            rd_data[7:0] = ctrl;
        end else if (addr == REG_STATUS) begin
            rd_data[ST_BUSY]                  = busy;
            rd_data[ST_WR_DONE]               = wr_done;
            rd_data[ST_RD_DONE]               = rd_done;
            rd_data[ST_PTR_LSB+3:ST_PTR_LSB]  = ptr;
        end else if (addr >= BANK_BASE) begin
            rd_data[7:0] = bank[addr[3:0]];
        end
    end

endmodule

// File: tb/tb_chu_i2c_target_core.sv
// Bench for chu_i2c_target_core: bit-banged I2C controller plus slot accesses,
// checked against a transaction-level model of the bank, pointer and sticky flags.
module tb_chu_i2c_target_core;
    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        scl = 1'b1;
    logic        sda_lo = 1'b0;
    wire         sda;

    assign sda = sda_lo ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    chu_i2c_target_core #(.FILT(3)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .rd_data(rd_data), .wr_data(wr_data), .scl(scl), .sda(sda)
    );

    int checks = 0;
    int errors = 0;
    int drv_cnt = 0;

    // Count cycles where the line is low although the bench is not pulling it.
    always @(negedge clk) if (sda === 1'b0 && !sda_lo) drv_cnt++;

    logic [7:0] m_bank [16];
    int         m_ptr;
    bit         m_wr, m_rd;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
        m_ptr = 0; m_wr = 0; m_rd = 0;
    endfunction

    function automatic void model_store(input logic [7:0] b);
        m_bank[4'(m_ptr)] = b;
        m_ptr = (m_ptr + 1) % 16;
        m_wr = 1;
    endfunction

    function automatic logic [31:0] exp_status();
        return 32'((m_ptr % 16) * 256 + (m_rd ? 4 : 0) + (m_wr ? 2 : 0));
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic slot_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1; write = 1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 0; write = 0;
        if (a == 5'd1) begin
            if (d[1]) m_wr = 0;
            if (d[2]) m_rd = 0;
        end else if (a >= 5'd16) begin
            m_bank[a[3:0]] = d[7:0];
        end
    endtask

    task automatic slot_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1; read = 1; addr = a;
        #1 d = rd_data;
        cs = 0; read = 0;
    endtask

    // glitch 1: 2-cycle scl low pulse; glitch 2: 1-cycle sda toggle; both while scl is high.
    task automatic i2c_bit(input bit b, input int glitch, output bit s);
        sda_lo = !b; wait_clk(Q);
        scl = 1; wait_clk(Q);
        s = sda;
        if (glitch == 1) begin
            scl = 0; wait_clk(2); scl = 1;
        end else if (glitch == 2) begin
            sda_lo = b; wait_clk(1); sda_lo = !b;
        end
        wait_clk(Q);
        scl = 0; wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_lo = 0; wait_clk(Q);
        scl = 1;    wait_clk(Q);
        sda_lo = 1; wait_clk(Q);
        scl = 0;    wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_lo = 1; wait_clk(Q);
        scl = 1;    wait_clk(Q);
        sda_lo = 0; wait_clk(2 * Q);
    endtask

    task automatic i2c_wr(input logic [7:0] b, input int gbit, input int gkind, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], (i == gbit) ? gkind : 0, s);
        i2c_bit(1'b1, 0, s);
        ack = !s;
    endtask

    task automatic i2c_rd(input bit nack, output logic [7:0] b);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, 0, s);
            b[i] = s;
        end
        i2c_bit(nack, 0, s);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int base;
        reset = 0; wait_clk(5); reset = 1;
        model_reset();
        base = drv_cnt;
        slot_read(5'd0, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
        slot_read(5'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
        for (int i = 0; i < 16; i++) begin
            slot_read(5'(16 + i), d); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_bank%0d got %h want 0", i, d); end
        end
        wait_clk(100); checks++;
        if (drv_cnt != base || sda !== 1'b1) begin
            errors++; $display("FAIL reset_sda driven %0d cycles, level %b, want 0 cycles, 1", drv_cnt - base, sda);
        end
    endtask

    task automatic test_write_wrap();
        logic [31:0] d;
        logic [7:0]  bytes [4];
        bit          ack;
        bytes = '{8'h84, 8'h0E, 8'hA5, 8'h5A};
        slot_write(5'd0, 32'hC2);
        i2c_start();
        for (int k = 0; k < 4; k++) begin
            i2c_wr(bytes[k], -1, 0, ack); checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL wrap_ack%0d got %b want 1", k, ack); end
            if (k == 0) begin
                slot_read(5'd1, d); checks++;
                if (d[0] !== 1'b1) begin errors++; $display("FAIL wrap_busy got %b want 1", d[0]); end
            end
            if (k == 1) m_ptr = 14;
            if (k >= 2) model_store(bytes[k]);
        end
        i2c_stop();
        slot_read(5'd30, d); checks++;
        if (d !== 32'(m_bank[14])) begin errors++; $display("FAIL wrap_bank14 got %h want %h", d, m_bank[14]); end
        slot_read(5'd31, d); checks++;
        if (d !== 32'(m_bank[15])) begin errors++; $display("FAIL wrap_bank15 got %h want %h", d, m_bank[15]); end
        slot_read(5'd1, d); checks++;
        if (d !== exp_status()) begin errors++; $display("FAIL wrap_status got %h want %h", d, exp_status()); end
    endtask

    task automatic test_read();
        logic [31:0] d;
        logic [7:0]  b;
        bit          ack;
        slot_write(5'd19, 32'h3C);
        slot_write(5'd20, 32'hC3);
        i2c_start();
        i2c_wr(8'h84, -1, 0, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_w_ack got %b want 1", ack); end
        i2c_wr(8'h03, -1, 0, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rd_ptr_ack got %b want 1", ack); end
        m_ptr = 3;
        i2c_start();
        i2c_wr(8'h85, -1, 0, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_r_ack got %b want 1", ack); end
        for (int k = 0; k < 2; k++) begin
            i2c_rd(k == 1, b); checks++;
            if (b !== m_bank[4'(m_ptr)]) begin errors++; $display("FAIL rd_byte%0d got %h want %h", k, b, m_bank[4'(m_ptr)]); end
            m_ptr = (m_ptr + 1) % 16;
        end
        m_rd = 1;
        wait_clk(Q); checks++;
        if (sda !== 1'b1) begin errors++; $display("FAIL rd_release got %b want 1", sda); end
        i2c_stop();
        slot_read(5'd1, d); checks++;
        if (d !== exp_status()) begin errors++; $display("FAIL rd_status got %h want %h", d, exp_status()); end
    endtask

    task automatic test_nomatch();
        logic [31:0] d;
        bit          ack;
        int          base;
        base = drv_cnt;
        i2c_start();
        i2c_wr(8'h86, -1, 0, ack); checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL nm_addr_ack got %b want 0", ack); end
        i2c_wr(8'h11, -1, 0, ack); checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL nm_data_ack got %b want 0", ack); end
        i2c_stop();
        checks++;
        if (drv_cnt != base) begin errors++; $display("FAIL nm_sda driven %0d cycles want 0", drv_cnt - base); end
        slot_read(5'd1, d); checks++;
        if (d !== exp_status()) begin errors++; $display("FAIL nm_status got %h want %h", d, exp_status()); end
        for (int i = 0; i < 16; i++) begin
            slot_read(5'(16 + i), d); checks++;
            if (d !== 32'(m_bank[i])) begin errors++; $display("FAIL nm_bank%0d got %h want %h", i, d, m_bank[i]); end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [7:0]  p, b [3];
        bit          ack;
        p    = 8'($urandom);
        b[0] = 8'($urandom);
        b[1] = 8'($urandom) | 8'h08;
        b[2] = 8'($urandom) & 8'hBF;
        i2c_start();
        i2c_wr(8'h84, -1, 0, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL gl_addr_ack got %b want 1", ack); end
        i2c_wr(p, -1, 0, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL gl_ptr_ack got %b want 1", ack); end
        m_ptr = p % 16;
        i2c_wr(b[0], 4, 1, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL gl_scl_ack got %b want 1", ack); end
        model_store(b[0]);
        i2c_wr(b[1], 3, 2, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL gl_start_ack got %b want 1", ack); end
        model_store(b[1]);
        i2c_wr(b[2], 6, 2, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL gl_stop_ack got %b want 1", ack); end
        model_store(b[2]);
        i2c_stop();
        for (int i = 0; i < 16; i++) begin
            slot_read(5'(16 + i), d); checks++;
            if (d !== 32'(m_bank[i])) begin errors++; $display("FAIL gl_bank%0d got %h want %h", i, d, m_bank[i]); end
        end
        slot_read(5'd1, d); checks++;
        if (d !== exp_status()) begin errors++; $display("FAIL gl_status got %h want %h", d, exp_status()); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0]  own, p, b;
        bit          ack;
        int          nw, nr;
        for (int it = 0; it < 5; it++) begin
            own = 8'($urandom_range(1, 127));
            slot_write(5'd0, 32'(own) | 32'h80);
            if ($urandom_range(0, 1) == 1) slot_write(5'(16 + $urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 1) == 1) slot_write(5'd1, 32'h6);
            nw = $urandom_range(0, 4);
            nr = $urandom_range(1, 4);
            p  = 8'($urandom);
            i2c_start();
            i2c_wr(own << 1, -1, 0, ack); checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL rnd%0d_waddr_ack got %b want 1", it, ack); end
            i2c_wr(p, -1, 0, ack); checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL rnd%0d_ptr_ack got %b want 1", it, ack); end
            m_ptr = p % 16;
            for (int k = 0; k < nw; k++) begin
                b = 8'($urandom);
                i2c_wr(b, -1, 0, ack); checks++;
                if (ack !== 1'b1) begin errors++; $display("FAIL rnd%0d_wdata%0d_ack got %b want 1", it, k, ack); end
                model_store(b);
            end
            i2c_start();
            i2c_wr((own << 1) | 8'h01, -1, 0, ack); checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL rnd%0d_raddr_ack got %b want 1", it, ack); end
            for (int k = 0; k < nr; k++) begin
                i2c_rd(k == nr - 1, b); checks++;
                if (b !== m_bank[4'(m_ptr)]) begin
                    errors++; $display("FAIL rnd%0d_rdata%0d got %h want %h", it, k, b, m_bank[4'(m_ptr)]);
                end
                m_ptr = (m_ptr + 1) % 16;
            end
            m_rd = 1;
            i2c_stop();
            slot_read(5'd1, d); checks++;
            if (d !== exp_status()) begin errors++; $display("FAIL rnd%0d_status got %h want %h", it, d, exp_status()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit          ack, s;
        int          base;
        slot_write(5'd0, 32'hC2);
        i2c_start();
        i2c_wr(8'h84, -1, 0, ack);
        i2c_wr(8'h07, -1, 0, ack); checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rm_ptr_ack got %b want 1", ack); end
        for (int i = 7; i >= 4; i--) i2c_bit(1'b1, 0, s);
        base = drv_cnt;
        reset = 0; wait_clk(2); reset = 1;
        model_reset();
        checks++;
        if (sda !== 1'b1 || drv_cnt != base) begin errors++; $display("FAIL rm_sda level %b driven %0d want 1, 0", sda, drv_cnt - base); end
        slot_read(5'd0, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rm_ctrl got %h want 0", d); end
        slot_read(5'd1, d); checks++;
        if (d !== exp_status()) begin errors++; $display("FAIL rm_status got %h want %h", d, exp_status()); end
        for (int i = 3; i >= 0; i--) i2c_bit(1'b1, 0, s);
        i2c_bit(1'b1, 0, s); checks++;
        if (s !== 1'b1) begin errors++; $display("FAIL rm_no_ack got %b want 1", s); end
        i2c_stop();
        slot_read(5'd23, d); checks++;
        if (d !== 32'(m_bank[7])) begin errors++; $display("FAIL rm_bank7 got %h want %h", d, m_bank[7]); end
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read();
        test_nomatch();
        test_glitch();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
